// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, forward S-box, GF(2^8) helpers and
// byte addressing for a column-major 128-bit state (byte 0 in bits 127:120).
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_e;

    // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int byte_idx(input int row, input int col);
        return row + 4 * col;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] blk, input int n);
        return blk[127 - 8 * n -: 8];
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns (skipped when final_round is set), then AddRoundKey.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] key,
    input  logic         final_round,
    output logic [127:0] next_state
);

    logic [15:0][7:0] sr;
    logic [15:0][7:0] mc;

    // Row r of output column c takes the substituted byte from column c+r.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[byte_idx(r, c)] = sbox(get_byte(state, byte_idx(r, (c + r) % 4)));
            end
        end
    end

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
    end

    always_comb begin
        next_state = '0;
        for (int n = 0; n < 16; n++) begin
            next_state[127 - 8*n -: 8] = (final_round ? sr[n] : mc[n]) ^ key[127 - 8*n -: 8];
        end
    end

endmodule

// File: rtl/aes_encryption.sv
// Iterative AES-128 encryption core: one round per clock, round keys fetched
// by address, ciphertext held with a valid flag until the next block starts.
module aes_encryption
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  read_fifo,
    input  logic                  is_full,
    input  logic [127:0]          fifo_in,
    input  logic [127:0]          round_key_input,
    output logic [KEY_ADDR_W-1:0] round_key_addr,
    output logic [127:0]          data_output,
    output logic                  data_done,
    output logic                  data_valid
);

    // A block is taken only in IDLE, on an edge where read_fifo=1 and is_full=0;
    // any read_fifo outside IDLE is dropped, so upstream must hold it until accepted.
    state_e       state, state_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic [3:0]   addr;
    logic [127:0] state_reg;
    logic [127:0] round_out;
    logic         accept;

    assign accept = (state == IDLE) && read_fifo && !is_full;

    aes_enc_round u_round (
        .state       (state_reg),
        .key         (round_key_input),
        .final_round (state == FINAL),
        .next_state  (round_out)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr      = 4'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ROUND;
                    cnt_nxt   = 4'd1;
                end
            end
            ROUND: begin
                addr    = cnt;
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'(NUM_ROUNDS - 1)) state_nxt = FINAL;
            end
            FINAL: begin
                addr      = 4'(NUM_ROUNDS);
                state_nxt = DONE;
            end
            DONE: begin
                cnt_nxt   = 4'd0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign round_key_addr = KEY_ADDR_W'(addr);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            state_reg   <= '0;
            data_output <= '0;
            data_done   <= 1'b0;
            data_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            data_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_reg  <= fifo_in ^ round_key_input;
                        data_valid <= 1'b0;
                    end
                end
                ROUND: state_reg <= round_out;
                FINAL: begin
                    state_reg   <= round_out;
                    data_output <= round_out;
                    data_valid  <= 1'b1;
                    data_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
